// File: rtl/fpcvt_arbiter_if.sv
// Request/response bundle for fpcvt_arbiter: two valid/ready operand ports and one tagged result port.
// master = producer/consumer side, slave = arbiter side.
interface fpcvt_arbiter_if;
  localparam int unsigned DW  = 12;
  localparam int unsigned IDW = 1;
  localparam int unsigned EW  = 3;
  localparam int unsigned FW  = 4;

  logic           req0_valid;
  logic [DW-1:0]  req0_data;
  logic           req0_ready;
  logic           req1_valid;
  logic [DW-1:0]  req1_data;
  logic           req1_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic           rsp_s;
  logic [EW-1:0]  rsp_e;
  logic [FW-1:0]  rsp_f;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_s, rsp_e, rsp_f
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_s, rsp_e, rsp_f
  );
endinterface

// File: rtl/fpcvt_arbiter.sv
// Round-robin share of one 12-bit two's-complement -> S/E[2:0]/F[3:0] converter between two requesters.
// Optional per-requester accept counters (cnt0/cnt1) when FPCVT_ARB_STATS_EN is defined.
module fpcvt_arbiter #(
  localparam int unsigned DW  = 12,
  localparam int unsigned IDW = 1,
  localparam int unsigned CW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fpcvt_arbiter_if.slave  bus
`ifdef FPCVT_ARB_STATS_EN
  ,
  output logic [CW-1:0]   cnt0,
  output logic [CW-1:0]   cnt1
`endif
);

  localparam int unsigned MW = DW - 1;

  typedef enum logic [1:0] {IDLE, CVT, HOLD} state_t;

  state_t         state, state_nxt;
  logic           prio;
  logic [DW-1:0]  opnd;
  logic [IDW-1:0] tag;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;

  logic [MW-1:0]  mag;
  logic [3:0]     lead;
  logic [3:0]     sh;
  logic           rnd;
  logic [4:0]     sum;
  logic [3:0]     e_w;
  logic           cvt_s;
  logic [2:0]     cvt_e;
  logic [3:0]     cvt_f;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = CVT;
      CVT:     state_nxt = HOLD;
      HOLD:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and ready decode; ready is only ever offered in IDLE
  always_comb begin
    gnt_vld        = 1'b0;
    gnt_id         = prio;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = prio;
      end else if (bus.req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (bus.req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      bus.req0_ready = gnt_vld && (gnt_id == 1'b0);
      bus.req1_ready = gnt_vld && (gnt_id == 1'b1);
    end
  end

  // Converter: sign-magnitude, round half-up on the first dropped bit, saturate at E=7/F=15
  always_comb begin
    mag   = '0;
    lead  = '0;
    sh    = '0;
    rnd   = 1'b0;
    sum   = '0;
    e_w   = '0;
    cvt_f = '0;
    cvt_s = opnd[DW-1];
    if (opnd == {1'b1, {(DW-1){1'b0}}}) mag = '1;
    else if (opnd[DW-1])                mag = MW'(-opnd);
    else                                mag = opnd[MW-1:0];
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) lead = 4'(i);
    end
    if (lead <= 4'd3) begin
      cvt_f = mag[3:0];
    end else begin
      sh    = lead - 4'd3;
      cvt_f = 4'(mag >> sh);
      rnd   = mag[sh - 4'd1];
      sum   = {1'b0, cvt_f} + {4'b0000, rnd};
      if (sum[4]) begin
        e_w   = sh + 4'd1;
        cvt_f = 4'd8;
      end else begin
        e_w   = sh;
        cvt_f = sum[3:0];
      end
    end
    if (e_w > 4'd7) begin
      e_w   = 4'd7;
      cvt_f = 4'd15;
    end
    cvt_e = e_w[2:0];
  end

  // Operand capture, round-robin pointer and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd          <= '0;
      tag           <= '0;
      prio          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_s     <= 1'b0;
      bus.rsp_e     <= '0;
      bus.rsp_f     <= '0;
    end else begin
      if (gnt_vld) begin
        opnd <= (gnt_id == 1'b1) ? bus.req1_data : bus.req0_data;
        tag  <= gnt_id;
        prio <= ~gnt_id;
      end
      if (state == CVT) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= tag;
        bus.rsp_s     <= cvt_s;
        bus.rsp_e     <= cvt_e;
        bus.rsp_f     <= cvt_f;
      end else if (state == HOLD && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FPCVT_ARB_STATS_EN
  // Accepted-request counters, free-running with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (bus.req0_valid && bus.req0_ready) cnt0 <= cnt0 + CW'(1);
      if (bus.req1_valid && bus.req1_ready) cnt1 <= cnt1 + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Directed bench for fpcvt_arbiter: conversion vectors, round-robin order, back-pressure and reset.
// Define FPCVT_ARB_STATS_EN to also exercise cnt0/cnt1.
module tb_fpcvt_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fpcvt_arbiter_if bus ();

`ifdef FPCVT_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;
  fpcvt_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus), .cnt0(cnt0), .cnt1(cnt1));
`else
  fpcvt_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request through the arbiter with rsp_ready held high
  task automatic run_one(input string tag, input int id, input logic [11:0] d,
                         input logic es, input logic [2:0] ee, input logic [3:0] ef);
    int   n;
    logic r;
    n = 0;
    if (id == 0) begin bus.req0_valid = 1'b1; bus.req0_data = d; end
    else         begin bus.req1_valid = 1'b1; bus.req1_data = d; end
    #1;
    r = (id == 0) ? bus.req0_ready : bus.req1_ready;
    while (!r && n < 10) begin
      step();
      n++;
      r = (id == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check({tag, "_rdy"}, 16'(r), 16'd1);
    step();
    if (id == 0) bus.req0_valid = 1'b0;
    else         bus.req1_valid = 1'b0;
    check({tag, "_cvt_vld"}, 16'(bus.rsp_valid), 16'd0);
    step();
    check({tag, "_vld"}, 16'(bus.rsp_valid), 16'd1);
    check({tag, "_id"},  16'(bus.rsp_id), 16'(id));
    check({tag, "_s"},   16'(bus.rsp_s), 16'(es));
    check({tag, "_e"},   16'(bus.rsp_e), 16'(ee));
    check({tag, "_f"},   16'(bus.rsp_f), 16'(ef));
    step();
    check({tag, "_done"}, 16'(bus.rsp_valid), 16'd0);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.rsp_ready  = 1'b0;

    // Reset values
    step();
    step();
    check("rst_vld",  16'(bus.rsp_valid), 16'd0);
    check("rst_id",   16'(bus.rsp_id), 16'd0);
    check("rst_s",    16'(bus.rsp_s), 16'd0);
    check("rst_e",    16'(bus.rsp_e), 16'd0);
    check("rst_f",    16'(bus.rsp_f), 16'd0);
    check("rst_rdy0", 16'(bus.req0_ready), 16'd0);
    check("rst_rdy1", 16'(bus.req1_ready), 16'd0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    step();

    // Single-requester conversions
    run_one("r0_422",   0, 12'd422,  1'b0, 3'd5, 4'd13);
    run_one("r1_125",   1, 12'd125,  1'b0, 3'd4, 4'd8);
    run_one("r1_m2048", 1, 12'h800,  1'b1, 3'd7, 4'd15);
    run_one("r1_2047",  1, 12'd2047, 1'b0, 3'd7, 4'd15);
    run_one("r0_zero",  0, 12'd0,    1'b0, 3'd0, 4'd0);
    run_one("r0_15",    0, 12'd15,   1'b0, 3'd0, 4'd15);
    run_one("r0_16",    0, 12'd16,   1'b0, 3'd1, 4'd8);
    run_one("r1_m5",    1, 12'hFFB,  1'b1, 3'd0, 4'd5);

    // Continuous dual requests after a fresh reset: grants alternate from requester 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 12'd24;
    bus.req1_valid = 1'b1; bus.req1_data = 12'hFFB;
    #1;
    check("dual_rdy0", 16'(bus.req0_ready), 16'd1);
    check("dual_rdy1", 16'(bus.req1_ready), 16'd0);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!bus.rsp_valid && n < 10) begin step(); n++; end
      check("dual_vld",  16'(bus.rsp_valid), 16'd1);
      check("dual_id",   16'(bus.rsp_id), 16'(k % 2));
      check("dual_s",    16'(bus.rsp_s), (k % 2 == 0) ? 16'd0 : 16'd1);
      check("dual_e",    16'(bus.rsp_e), (k % 2 == 0) ? 16'd1 : 16'd0);
      check("dual_f",    16'(bus.rsp_f), (k % 2 == 0) ? 16'd12 : 16'd5);
      check("dual_hrdy", 16'({bus.req0_ready, bus.req1_ready}), 16'd0);
      if (k == 5) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
      step();
      check("dual_rel", 16'(bus.rsp_valid), 16'd0);
    end
    step();

    // Back-pressure in HOLD with a pending requester 0
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 12'hFE7;
    #1;
    check("bp_rdy1", 16'(bus.req1_ready), 16'd1);
    step();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 12'd16;
    #1;
    check("bp_cvt_rdy0", 16'(bus.req0_ready), 16'd0);
    step();
    check("bp_vld", 16'(bus.rsp_valid), 16'd1);
    check("bp_id",  16'(bus.rsp_id), 16'd1);
    check("bp_s",   16'(bus.rsp_s), 16'd1);
    check("bp_e",   16'(bus.rsp_e), 16'd1);
    check("bp_f",   16'(bus.rsp_f), 16'd13);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_vld",  16'(bus.rsp_valid), 16'd1);
      check("bp_hold_id",   16'(bus.rsp_id), 16'd1);
      check("bp_hold_ef",   16'({bus.rsp_s, bus.rsp_e, bus.rsp_f}), 16'({1'b1, 3'd1, 4'd13}));
      check("bp_hold_rdy0", 16'(bus.req0_ready), 16'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_rel_rdy0", 16'(bus.req0_ready), 16'd0);
    step();
    check("bp_idle_vld",  16'(bus.rsp_valid), 16'd0);
    check("bp_idle_rdy0", 16'(bus.req0_ready), 16'd1);
    step();
    bus.req0_valid = 1'b0;
    step();
    check("bp_r0_vld", 16'(bus.rsp_valid), 16'd1);
    check("bp_r0_id",  16'(bus.rsp_id), 16'd0);
    check("bp_r0_sef", 16'({bus.rsp_s, bus.rsp_e, bus.rsp_f}), 16'({1'b0, 3'd1, 4'd8}));
    step();

    // Reset asserted while a conversion is in flight
    bus.req0_valid = 1'b1; bus.req0_data = 12'd422;
    #1;
    check("rc_rdy0", 16'(bus.req0_ready), 16'd1);
    step();
    bus.req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rc_vld_now", 16'(bus.rsp_valid), 16'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rc_vld", 16'(bus.rsp_valid), 16'd0);
    end
    rst_n = 1'b1;
    step();
    check("rc_post_vld", 16'(bus.rsp_valid), 16'd0);
    bus.req0_valid = 1'b1; bus.req0_data = 12'd125;
    bus.req1_valid = 1'b1; bus.req1_data = 12'd2047;
    #1;
    check("rc_prio0", 16'(bus.req0_ready), 16'd1);
    check("rc_prio1", 16'(bus.req1_ready), 16'd0);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    check("rc_r_vld", 16'(bus.rsp_valid), 16'd1);
    check("rc_r_id",  16'(bus.rsp_id), 16'd0);
    check("rc_r_sef", 16'({bus.rsp_s, bus.rsp_e, bus.rsp_f}), 16'({1'b0, 3'd4, 4'd8}));
    step();
    step();

`ifdef FPCVT_ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("st_rst0", cnt0, 16'd0);
    check("st_rst1", cnt1, 16'd0);
    run_one("st_a", 0, 12'd422, 1'b0, 3'd5, 4'd13);
    run_one("st_b", 1, 12'd125, 1'b0, 3'd4, 4'd8);
    run_one("st_c", 0, 12'd16,  1'b0, 3'd1, 4'd8);
    run_one("st_d", 1, 12'hFFB, 1'b1, 3'd0, 4'd5);
    run_one("st_e", 0, 12'd15,  1'b0, 3'd0, 4'd15);
    check("st_cnt0", cnt0, 16'd3);
    check("st_cnt1", cnt1, 16'd2);
    rst_n = 1'b0;
    #1;
    check("st_clr0", cnt0, 16'd0);
    check("st_clr1", cnt1, 16'd0);
    step();
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
